// File: rtl/hrv_pkg.sv
// Shared types and constants for the HRV front end (RR extraction and RMSSD).
package hrv_pkg;

  typedef enum logic [1:0] {
    SEEK    = 2'd0,
    TRACK   = 2'd1,
    REFRACT = 2'd2
  } rr_state_t;

  localparam int RR_W               = 8;
  localparam int CNT_W_DEFAULT      = 12;
  localparam int REFRACT_LEN_DEFAULT = 40;
  localparam int SCALE_SHIFT_DEFAULT = 2;

endpackage

// File: rtl/rr_interval_extractor.sv
// R-peak detector: threshold/max tracking with a refractory window, emitting the
// scaled, saturated sample distance between successive peak maxima.
module rr_interval_extractor
  import hrv_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int REFRACT_LEN = REFRACT_LEN_DEFAULT,
  parameter int SCALE_SHIFT = SCALE_SHIFT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      sample_in,
  input  logic            sample_valid,
  input  logic [7:0]      threshold,
  output logic [RR_W-1:0] rr_out,
  output logic            rr_valid,
  output logic            peak_pulse,
  output logic            overflow
);

  localparam int REF_W = (REFRACT_LEN < 2) ? 1 : $clog2(REFRACT_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  rr_state_t         state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [CNT_W-1:0]  max_pos_reg, max_pos_next;
  logic [CNT_W-1:0]  since_max_reg, since_max_next;
  logic [7:0]        max_val_reg, max_val_next;
  logic [REF_W-1:0]  ref_cnt_reg, ref_cnt_next;
  logic              have_prev_reg, have_prev_next;
  logic              overflow_reg, overflow_next;
  logic [RR_W-1:0]   rr_out_reg, rr_out_next;
  logic              rr_valid_reg, rr_valid_next;
  logic              peak_pulse_reg, peak_pulse_next;

  logic [CNT_W-1:0]  cnt_inc;
  logic [CNT_W-1:0]  since_inc;
  logic              sat_hit;

  function automatic logic [RR_W-1:0] scale_clip(input logic [CNT_W-1:0] c);
    logic [CNT_W+RR_W-1:0] wide;
    wide = {{RR_W{1'b0}}, c} >> SCALE_SHIFT;
    if (wide > (CNT_W+RR_W)'((1 << RR_W) - 1))
      return '1;
    return wide[RR_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= SEEK;
      cnt_reg        <= '0;
      max_pos_reg    <= '0;
      since_max_reg  <= '0;
      max_val_reg    <= '0;
      ref_cnt_reg    <= '0;
      have_prev_reg  <= 1'b0;
      overflow_reg   <= 1'b0;
      rr_out_reg     <= '0;
      rr_valid_reg   <= 1'b0;
      peak_pulse_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      max_pos_reg    <= max_pos_next;
      since_max_reg  <= since_max_next;
      max_val_reg    <= max_val_next;
      ref_cnt_reg    <= ref_cnt_next;
      have_prev_reg  <= have_prev_next;
      overflow_reg   <= overflow_next;
      rr_out_reg     <= rr_out_next;
      rr_valid_reg   <= rr_valid_next;
      peak_pulse_reg <= peak_pulse_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    max_pos_next    = max_pos_reg;
    since_max_next  = since_max_reg;
    max_val_next    = max_val_reg;
    ref_cnt_next    = ref_cnt_reg;
    have_prev_next  = have_prev_reg;
    overflow_next   = overflow_reg;
    rr_out_next     = rr_out_reg;
    rr_valid_next   = 1'b0;
    peak_pulse_next = 1'b0;

    cnt_inc   = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + 1'b1;
    since_inc = (since_max_reg == CNT_MAX) ? CNT_MAX : since_max_reg + 1'b1;
    sat_hit   = (cnt_reg == CNT_MAX - 1'b1);

    if (sample_valid) begin
      cnt_next       = cnt_inc;
      since_max_next = since_inc;
      // Only the transition into saturation invalidates the reference peak.
      if (sat_hit) begin
        overflow_next  = 1'b1;
        have_prev_next = 1'b0;
      end

      unique case (state_reg)
        SEEK: begin
          if (sample_in >= threshold) begin
            state_next     = TRACK;
            max_val_next   = sample_in;
            max_pos_next   = cnt_inc;
            since_max_next = '0;
          end
        end

        TRACK: begin
          if (sample_in >= threshold) begin
            if (sample_in > max_val_reg) begin
              max_val_next   = sample_in;
              max_pos_next   = cnt_inc;
              since_max_next = '0;
            end
          end else begin
            peak_pulse_next = 1'b1;
            if (have_prev_reg && !sat_hit) begin
              rr_out_next   = scale_clip(max_pos_reg);
              rr_valid_next = 1'b1;
            end
            have_prev_next = 1'b1;
            overflow_next  = 1'b0;
            // Samples since the maximum equal (cnt+1)-max_pos, and stay exact
            // even when cnt was pinned at saturation.
            cnt_next       = since_inc;
            ref_cnt_next   = REF_W'(REFRACT_LEN);
            state_next     = REFRACT;
          end
        end

        REFRACT: begin
          ref_cnt_next = (ref_cnt_reg != '0) ? ref_cnt_reg - 1'b1 : '0;
          if (ref_cnt_reg <= REF_W'(1))
            state_next = SEEK;
        end

        default: state_next = SEEK;
      endcase
    end
  end

  assign rr_out     = rr_out_reg;
  assign rr_valid   = rr_valid_reg;
  assign peak_pulse = peak_pulse_reg;
  assign overflow   = overflow_reg;

endmodule

// File: doc/rr_interval_extractor.md
# rr_interval_extractor

- Stage directly upstream of the RMSSD engine.
- Input is a stream of 8-bit ECG samples. The block detects R-peaks with a threshold/max-tracking state machine and a refractory window.
- It measures the sample count between successive peak maxima and emits each RR interval as a scaled, saturated 8-bit value with a one-cycle strobe. `rr_out`/`rr_valid` connect straight to the RMSSD block's `rr_in`/`valid`.

## Interface
- `CNT_W`, default 12: width of the inter-peak sample counter.
- `REFRACT_LEN`, default 40: samples ignored after each confirmed peak.
- `SCALE_SHIFT`, default 2: right shift applied to the sample count to form `rr_out`.
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `sample_in`, input, 8: unsigned ECG sample.
- `sample_valid`, input, 1: `sample_in` is valid this cycle. The block advances only on these cycles.
- `threshold`, input, 8: peak detection level. Sampled on every valid sample.
- `rr_out`, output, 8: last RR interval, `min(count >> SCALE_SHIFT, 255)`. Held until the next strobe.
- `rr_valid`, output, 1: one-cycle strobe when a new `rr_out` is loaded.
- `peak_pulse`, output, 1: one-cycle strobe on every confirmed peak, including ones that produce no interval.
- `overflow`, output, 1: sticky. Set when the counter saturates. Cleared on the next confirmed peak.

## Operation
- **States:** SEEK, TRACK, REFRACT.
- **`cnt`:** increments on every valid sample in all states. It saturates at `2^CNT_W-1`, which sets `overflow` and clears `have_prev`.
- **SEEK:** when `sample_in >= threshold`, go to TRACK with `max_val = sample_in` and `max_pos = cnt+1`.
- **TRACK, sample at or above threshold:** if `sample_in > max_val` (strict), update `max_val` and set `max_pos = cnt+1`. Ties keep the earlier position.
- **TRACK, sample below threshold:** the peak is confirmed.
  - Pulse `peak_pulse`.
  - If `have_prev` is set, load `rr_out` from `max_pos` and pulse `rr_valid`.
  - Set `have_prev = 1` and clear `overflow`.
  - Set `cnt = (cnt+1) - max_pos`, so the count restarts at the peak maximum.
  - Load `ref_cnt = REFRACT_LEN` and go to REFRACT.
- **REFRACT:** decrement `ref_cnt` on each valid sample and ignore the sample value. At 0, go to SEEK, even if the sample is still above threshold.
- **First peak after reset or overflow:** produces `peak_pulse` only. There is no previous reference, so no `rr_valid`.
- **Arithmetic:**
  - `cnt`, `max_pos` and the subtraction are unsigned `CNT_W`.
  - `max_pos <= cnt+1` always holds, so the subtraction never wraps.
  - Scaling is a pure right shift, clipped to 255.
- **Saturation inside TRACK:** if `cnt` saturates while in TRACK, the peak still confirms, but `rr_valid` is suppressed.
- **`sample_valid` low:** nothing changes. The state, counters and outputs hold.
- **Reset, including mid-operation:**
  - State returns to SEEK.
  - `cnt`, `max_pos`, `max_val`, `ref_cnt`, `have_prev` and `overflow` clear to 0.
  - `rr_out = 0`, `rr_valid = 0`, `peak_pulse = 0`.

## Timing
- All outputs are registered.
- `rr_valid` and `peak_pulse` go high in the cycle after the clock edge that accepts the confirming sample, and stay high for exactly one cycle.
- Latency from the peak-maximum sample to the strobe equals the number of valid samples until the signal drops below threshold, plus 1 clock.
- Minimum spacing between strobes is `REFRACT_LEN+2` valid samples. The consumer needs no backpressure; there is no ready input.
- `rr_out` changes only in the `rr_valid` cycle. It is stable whenever the downstream block samples it.
- A threshold change takes effect on the next valid sample.

## Structure
- `hrv_pkg` holds:
  - the state enum (SEEK/TRACK/REFRACT);
  - the RR width constant (8);
  - the default `CNT_W`, `REFRACT_LEN` and `SCALE_SHIFT` values.
  
  The RMSSD stage shares the RR width constant.
- Single module, no sub-modules. The shift-and-clip is an inline function.

## Test plan
All scenarios use `threshold=100`, `SCALE_SHIFT=2` and `REFRACT_LEN=40` unless stated.

- **Reset:** assert `rst_n` low mid-TRACK.
  - All outputs read 0 and the state is SEEK.
  - The first peak after release gives `peak_pulse` with no `rr_valid`.
- **Periodic peaks:** triangular peaks (max 200) every 400 valid samples.
  - The first peak gives `peak_pulse` only.
  - Each later peak gives `rr_valid` with `rr_out=100`.
- **Saturation of `rr_out`:** peaks 1100 samples apart.
  - `rr_out=255` (1100>>2 = 275, clipped).
  - `overflow` stays 0.
- **Refractory window:** a second above-threshold bump 20 samples after a confirmed peak.
  - No `peak_pulse` for that bump.
  - The next real peak at 400 gives `rr_out=100`.
- **Flat-top tie:** a peak holding 180 for 5 samples.
  - `max_pos` is the first 180 sample.
  - The interval is measured from that sample.
- **Counter overflow, then stalls:** no peak for 5000 samples, then `sample_valid` gaps between later peaks.
  - `overflow` goes to 1 and the next peak gives `peak_pulse` with no `rr_valid`.
  - `overflow` clears on that peak.
  - The following peak 400 samples later gives `rr_out=100`, regardless of the invalid cycles inserted.
